// File: rtl/wse_pkg.sv
// Shared definitions for the word search engine: delimiters, FSM states and
// the optional case-fold helper (enabled by WSE_CASE_FOLD_EN).
package wse_pkg;

   localparam logic [7:0] CH_SP  = 8'h20;
   localparam logic [7:0] CH_ETX = 8'h03;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

`ifdef WSE_CASE_FOLD_EN
   function automatic logic [7:0] fold_case(input logic [7:0] ch);
      fold_case = (ch >= 8'h61 && ch <= 8'h7A) ? (ch - 8'h20) : ch;
   endfunction
`endif

endpackage

// File: rtl/wse_key_cmp.sv
// Compares the assembled word buffer against one search key.
// Case-insensitive when WSE_CASE_FOLD_EN is defined, exact otherwise.
module wse_key_cmp
   import wse_pkg::*;
#(
   parameter int MAX_LEN = 5
) (
   input  logic [MAX_LEN*8-1:0] word,
   input  logic [MAX_LEN*8-1:0] key,
   output logic                 match
);

`ifdef WSE_CASE_FOLD_EN
   logic [MAX_LEN*8-1:0] word_f;
   logic [MAX_LEN*8-1:0] key_f;

   always_comb begin
      word_f = '0;
      key_f  = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         word_f[i*8 +: 8] = fold_case(word[i*8 +: 8]);
         key_f[i*8 +: 8]  = fold_case(key[i*8 +: 8]);
      end
      match = (word_f == key_f);
   end
`else
   always_comb begin
      match = (word == key);
   end
`endif

endmodule

// File: rtl/word_search_engine.sv
// Scans SRAM text for space/ETX delimited words matching up to NUM_KEYS keys.
// Optional case-insensitive matching via WSE_CASE_FOLD_EN; the start port is
// new_search because 'new' is a reserved word in SystemVerilog.
module word_search_engine
   import wse_pkg::*;
#(
   parameter int MAX_LEN  = 5,
   parameter int NUM_KEYS = 4,
   parameter int ADDR_W   = 12,
   parameter int CNT_W    = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        new_search,
   input  logic [NUM_KEYS*MAX_LEN*8-1:0] keys,
   input  logic [7:0]                  data,
   input  logic                        data_valid,
   output logic [ADDR_W-1:0]           addr,
   output logic                        busy,
   output logic                        done,
   output logic [NUM_KEYS-1:0]         found,
   output logic [NUM_KEYS-1:0]         not_found,
   output logic [NUM_KEYS*CNT_W-1:0]   hit_count,
   output logic                        overrun
);

   localparam int CW = $clog2(MAX_LEN + 1);
   localparam logic [CW-1:0] LEN_MAX = CW'(MAX_LEN);

   state_t                        state;
   logic [NUM_KEYS*MAX_LEN*8-1:0] key_q;
   logic [MAX_LEN*8-1:0]          word_q;
   logic [CW-1:0]                 char_cnt;
   logic                          too_long;
   logic [NUM_KEYS-1:0]           match_vec;
   logic [NUM_KEYS-1:0]           hit_vec;
   logic                          is_delim;
   logic                          is_etx;
   logic                          addr_max;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_cmp
      wse_key_cmp #(.MAX_LEN(MAX_LEN)) u_cmp (
         .word  (word_q),
         .key   (key_q[k*MAX_LEN*8 +: MAX_LEN*8]),
         .match (match_vec[k])
      );
   end

   always_comb begin
      is_etx   = (data == CH_ETX);
      is_delim = (data == CH_SP) || is_etx;
      addr_max = &addr;
      hit_vec  = '0;
      if (is_delim && (char_cnt != '0) && !too_long)
         hit_vec = match_vec;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         key_q     <= '0;
         word_q    <= '0;
         char_cnt  <= '0;
         too_long  <= 1'b0;
         addr      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         found     <= '0;
         not_found <= '0;
         hit_count <= '0;
         overrun   <= 1'b0;
      end else if (new_search) begin
         state     <= SCAN;
         key_q     <= keys;
         word_q    <= '0;
         char_cnt  <= '0;
         too_long  <= 1'b0;
         addr      <= '0;
         busy      <= 1'b1;
         done      <= 1'b0;
         found     <= '0;
         not_found <= '0;
         hit_count <= '0;
         overrun   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
            end
            SCAN: begin
               if (data_valid) begin
                  addr <= addr + ADDR_W'(1);
                  if (addr_max && !is_etx) begin
                     // Last address without ETX: drop the partial word, no compare.
                     overrun   <= 1'b1;
                     char_cnt  <= '0;
                     too_long  <= 1'b0;
                     state     <= DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     not_found <= ~found;
                  end else if (is_delim) begin
                     char_cnt <= '0;
                     too_long <= 1'b0;
                     found    <= found | hit_vec;
                     for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                        if (hit_vec[k] && (hit_count[k*CNT_W +: CNT_W] != '1))
                           hit_count[k*CNT_W +: CNT_W] <= hit_count[k*CNT_W +: CNT_W] + CNT_W'(1);
                     end
                     if (is_etx) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        not_found <= ~(found | hit_vec);
                     end
                  end else if (char_cnt == LEN_MAX) begin
                     too_long <= 1'b1;
                  end else begin
                     // First character of a word also clears stale trailing bytes.
                     for (int unsigned i = 0; i < MAX_LEN; i++) begin
                        if (char_cnt == CW'(i))
                           word_q[(MAX_LEN-1-i)*8 +: 8] <= data;
                        else if (char_cnt == '0)
                           word_q[(MAX_LEN-1-i)*8 +: 8] <= '0;
                     end
                     char_cnt <= char_cnt + CW'(1);
                  end
               end
            end
            DONE: begin
               busy <= 1'b0;
               done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/word_search_engine.md
WORD_SEARCH_ENGINE -- requirements
Module: word_search_engine

Interface
REQ-001 Parameter MAX_LEN, default 5, maximum characters per word and key.
REQ-002 Parameter NUM_KEYS, default 4, number of search keys matched in parallel.
REQ-003 Parameter ADDR_W, default 12, width of the SRAM byte address.
REQ-004 Parameter CNT_W, default 8, width of each per-key hit counter.
REQ-005 The block SHALL have these ports:
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- new  in  1  start search pulse.
- keys  in  NUM_KEYS*MAX_LEN*8  search keys, key k at slice k; first char in the MSB byte; zero-padded.
- data  in  8  SRAM read byte for the current addr.
- data_valid  in  1  data is valid this cycle.
- addr  out  ADDR_W  SRAM byte address.
- busy  out  1  scan in progress.
- done  out  1  scan finished; held until the next new.
- found  out  NUM_KEYS  per-key hit seen.
- not_found  out  NUM_KEYS  per-key result, valid with done.
- hit_count  out  NUM_KEYS*CNT_W  per-key hit totals.
- overrun  out  1  addr wrapped without ETX.

Function
REQ-006 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-007 new SHALL act from any state: latch keys; clear word buffer, char count, found, hit_count and overrun; set addr to 0; enter SCAN on the next cycle.
REQ-008 In SCAN, addr SHALL increment by 1 on every cycle with data_valid=1; addr SHALL hold when data_valid=0.
REQ-009 A non-delimiter byte accepted at char count c < MAX_LEN SHALL be written into buffer byte c.
- Char count c=0 SHALL also zero the rest of the buffer.
- Char count SHALL increment with each such byte.
REQ-010 A non-delimiter byte accepted at c = MAX_LEN SHALL set an internal too-long flag for the current word; the buffer is unchanged.
REQ-011 A delimiter (0x20 space or 0x03 ETX) SHALL compare the buffer against every key when c>0 and too-long=0.
- An empty word (consecutive delimiters) SHALL never match.
REQ-012 On a match for key k, found[k] SHALL be set and hit_count[k] SHALL increment, both registered one cycle after the delimiter is accepted; hit_count[k] SHALL saturate at all-ones.
REQ-013 Several keys SHALL be allowed to match the same word in the same cycle; each updates independently.
REQ-014 After any delimiter, char count and too-long SHALL clear.
REQ-015 An accepted ETX SHALL complete its compare and then enter DONE.
REQ-016 When addr is all-ones and data_valid=1 with a non-ETX byte, the block SHALL set overrun, discard the partial word without a compare, and enter DONE.
REQ-017 In DONE: done=1, busy=0, not_found = ~found, addr held; data and data_valid ignored.
REQ-018 In IDLE: busy=0 and done=0. new asserted in the same cycle as data_valid SHALL win, and that data byte SHALL be discarded.
REQ-019 not_found SHALL read 0 whenever done=0.

Reset
REQ-020 reset SHALL take priority over new and SHALL place the FSM in IDLE.
REQ-021 reset SHALL clear all outputs to 0: addr, busy, done, found, not_found, hit_count, overrun.
REQ-022 reset SHALL clear the latched keys to 0, the buffer, char count and too-long.
REQ-023 reset mid-scan SHALL abort the scan with no result retained.

Configuration
REQ-024 Macro WSE_CASE_FOLD_EN.
- When defined: ASCII 0x61-0x7A SHALL be folded to 0x41-0x5A on both the buffer byte and the latched key bytes before compare, making matching case-insensitive.
- When undefined: matching SHALL be exact byte equality, and no fold logic is present.

Structure
REQ-025 Package wse_pkg SHALL hold:
- delimiter constants CH_SP=0x20 and CH_ETX=0x03;
- the FSM state enum (IDLE, SCAN, DONE);
- a case-fold function, used only under WSE_CASE_FOLD_EN.
REQ-026 Sub-module wse_key_cmp, one instance per key via generate, SHALL compare the buffer against one key and return a match bit.

Verification
REQ-027 Key0="CAT", memory "THE CAT SAT\x03" -> found=0001, hit_count[0]=1, done after 12 accepted bytes, addr=12.
REQ-028 Key0="AB", key1="AB", memory "AB AB  AB\x03" -> found=0011, hit_count[0]=hit_count[1]=3; the double space produces no match.
REQ-029 MAX_LEN=5, key0="HELLO", memory "HELLOS HELLO\x03" -> hit_count[0]=1; the 6-char word is rejected via too-long.
REQ-030 CNT_W=2, key0="A", memory holds "A " seven times then ETX -> hit_count[0]=3 (saturated).
REQ-031 ADDR_W=4, 16 non-ETX bytes -> overrun=1, done=1, not_found=all-ones.
REQ-032 Sequence checks:
- new pulsed mid-scan -> counters clear and addr=0 next cycle;
- reset mid-scan -> all outputs 0;
- with WSE_CASE_FOLD_EN, key "cat" matches "CAT".
